// File: rtl/ram_slot_if.sv
// Bus between the slot arbiter and its requesters/RAM pins: strobes, requests, acks and
// the multiplexed DRAM interface. clk32/res stay outside as plain ports.
interface ram_slot_if #(
    parameter int RA_W = 10
);
    logic                slot_en;
    logic                addrsel_en;
    logic                latch_en;

    // Handshake: a requester raises *_req (level) with addr/we stable and holds all three
    // until it sees a one-clock *_ack; the ack is the only completion signal, never sent ungranted.
    logic                vid_req;
    logic [2*RA_W-1:0]   vid_addr;
    logic                dma_req;
    logic                dma_we;
    logic [2*RA_W-1:0]   dma_addr;
    logic                cpu_req;
    logic                cpu_we;
    logic [2*RA_W-1:0]   cpu_addr;

    logic                vid_ack;
    logic                dma_ack;
    logic                cpu_ack;
    logic [2:0]          owner;
    logic [RA_W-1:0]     ram_addr;
    logic                ram_we;
    logic                ras_n;
    logic                cas_n;
    logic [2:0]          ref_pending;
    logic [2:0]          dbg_state;

    modport slave (
        input  slot_en, addrsel_en, latch_en,
        input  vid_req, vid_addr, dma_req, dma_we, dma_addr, cpu_req, cpu_we, cpu_addr,
        output vid_ack, dma_ack, cpu_ack, owner, ram_addr, ram_we, ras_n, cas_n,
        output ref_pending, dbg_state
    );

    modport master (
        output slot_en, addrsel_en, latch_en,
        output vid_req, vid_addr, dma_req, dma_we, dma_addr, cpu_req, cpu_we, cpu_addr,
        input  vid_ack, dma_ack, cpu_ack, owner, ram_addr, ram_we, ras_n, cas_n,
        input  ref_pending, dbg_state
    );
endinterface

// File: rtl/ram_slot_arbiter.sv
// DRAM slot arbiter: picks refresh/video/DMA/CPU at each slot strobe and sequences
// RAS/CAS and the row/column address mux, acking the owner at the latch point.
module ram_slot_arbiter #(
    parameter int RA_W        = 10,
    parameter int REFRESH_DIV = 64,
    parameter int REF_MAX     = 3
) (
    input  logic      clk32,
    input  logic      res,
    ram_slot_if.slave bus
);
    localparam int              AW        = 2 * RA_W;
    localparam int              SC_W      = $clog2(REFRESH_DIV);
    localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(REFRESH_DIV - 1);
    localparam logic [3:0]      REF_MAX_W = 4'(REF_MAX);
    localparam logic [2:0]      REF_MAX_N = 3'(REF_MAX);

    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_REF  = 3'd1;
    localparam logic [2:0] OWN_VID  = 3'd2;
    localparam logic [2:0] OWN_DMA  = 3'd3;
    localparam logic [2:0] OWN_CPU  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROW   = 3'd1,
        S_COL   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [RA_W-1:0] ram_addr_q, ram_addr_d;
    logic            ras_n_q, ras_n_d;
    logic            cas_n_q, cas_n_d;
    logic            vid_ack_q, vid_ack_d;
    logic            dma_ack_q, dma_ack_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic [SC_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [RA_W-1:0] ref_row_q, ref_row_d;
    logic [2:0]      ref_pending_q, ref_pending_d;

    logic            restore;
    logic            wrap;
    logic            grant_ref;
    logic [3:0]      pend_eff;
    logic [3:0]      pend_new;
    logic [RA_W-1:0] ref_row_eff;
    logic [2:0]      grant;
    logic [AW-1:0]   grant_addr;
    logic            grant_we;

    // A refresh slot cut short by a strobe fault was already counted off at grant;
    // hand it back so this edge's arbitration sees it as still pending.
    always_comb begin
        restore     = bus.slot_en && (state_q != S_IDLE) && (state_q != S_DONE) &&
                      (owner_q == OWN_REF);
        pend_eff    = {1'b0, ref_pending_q} + {3'b000, restore};
        ref_row_eff = ref_row_q - RA_W'(restore);
        wrap        = bus.slot_en && (slot_cnt_q == SLOT_LAST);

        grant      = OWN_NONE;
        grant_addr = '0;
        grant_we   = 1'b0;
        if (pend_eff == REF_MAX_W) begin
            grant      = OWN_REF;
            grant_addr = {ref_row_eff, {RA_W{1'b0}}};
        end else if (bus.vid_req) begin
            grant      = OWN_VID;
            grant_addr = bus.vid_addr;
        end else if (pend_eff != 4'd0) begin
            grant      = OWN_REF;
            grant_addr = {ref_row_eff, {RA_W{1'b0}}};
        end else if (bus.dma_req) begin
            grant      = OWN_DMA;
            grant_addr = bus.dma_addr;
            grant_we   = bus.dma_we;
        end else if (bus.cpu_req) begin
            grant      = OWN_CPU;
            grant_addr = bus.cpu_addr;
            grant_we   = bus.cpu_we;
        end
        grant_ref = (grant == OWN_REF);
        pend_new  = pend_eff - {3'b000, grant_ref} + {3'b000, wrap};
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        ram_addr_d    = ram_addr_q;
        ras_n_d       = ras_n_q;
        cas_n_d       = cas_n_q;
        vid_ack_d     = 1'b0;
        dma_ack_d     = 1'b0;
        cpu_ack_d     = 1'b0;
        slot_cnt_d    = slot_cnt_q;
        ref_row_d     = ref_row_q;
        ref_pending_d = ref_pending_q;

        if (bus.slot_en) begin
            slot_cnt_d    = wrap ? '0 : slot_cnt_q + 1'b1;
            ref_pending_d = (pend_new > REF_MAX_W) ? REF_MAX_N : pend_new[2:0];
            ref_row_d     = ref_row_eff + RA_W'(grant_ref);
            owner_d       = grant;
            addr_d        = grant_addr;
            we_d          = grant_we;
            ras_n_d       = 1'b1;
            cas_n_d       = 1'b1;
            if (grant == OWN_NONE) begin
                state_d = S_IDLE;
            end else if (state_q == S_IDLE) begin
                state_d    = S_ROW;
                ras_n_d    = 1'b0;
                ram_addr_d = grant_addr[AW-1:RA_W];
            end else begin
                // Strobe fault: one clock with both strobes high before the new row opens.
                state_d = S_ABORT;
            end
        end else begin
            case (state_q)
                S_ABORT: begin
                    state_d    = S_ROW;
                    ras_n_d    = 1'b0;
                    ram_addr_d = addr_q[AW-1:RA_W];
                end
                S_ROW: begin
                    if (bus.addrsel_en) begin
                        state_d = S_COL;
                        if (owner_q != OWN_REF) begin
                            cas_n_d    = 1'b0;
                            ram_addr_d = addr_q[RA_W-1:0];
                        end
                    end
                end
                S_COL: begin
                    if (bus.latch_en) begin
                        state_d   = S_DONE;
                        ras_n_d   = 1'b1;
                        cas_n_d   = 1'b1;
                        vid_ack_d = (owner_q == OWN_VID);
                        dma_ack_d = (owner_q == OWN_DMA);
                        cpu_ack_d = (owner_q == OWN_CPU);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                    we_d    = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk32 or posedge res) begin
        if (res) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_NONE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            ram_addr_q    <= '0;
            ras_n_q       <= 1'b1;
            cas_n_q       <= 1'b1;
            vid_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
            cpu_ack_q     <= 1'b0;
            slot_cnt_q    <= '0;
            ref_row_q     <= '0;
            ref_pending_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            ram_addr_q    <= ram_addr_d;
            ras_n_q       <= ras_n_d;
            cas_n_q       <= cas_n_d;
            vid_ack_q     <= vid_ack_d;
            dma_ack_q     <= dma_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            slot_cnt_q    <= slot_cnt_d;
            ref_row_q     <= ref_row_d;
            ref_pending_q <= ref_pending_d;
        end
    end

    assign bus.owner       = owner_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = we_q;
    assign bus.ras_n       = ras_n_q;
    assign bus.cas_n       = cas_n_q;
    assign bus.vid_ack     = vid_ack_q;
    assign bus.dma_ack     = dma_ack_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.ref_pending = ref_pending_q;
    assign bus.dbg_state   = state_q;
endmodule
